// File: rtl/brs_pkg.sv
// rtl/brs_pkg.sv - shared opcode constants and helpers for the BRS barrel/rotate/reverse core
package brs_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned AMT_W  = 3;

    localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
    localparam logic [OP_W-1:0] OP_ROL  = 3'b001;
    localparam logic [OP_W-1:0] OP_ROR  = 3'b010;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b011;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b100;
    localparam logic [OP_W-1:0] OP_SAR  = 3'b101;
    localparam logic [OP_W-1:0] OP_BREV = 3'b110;
    localparam logic [OP_W-1:0] OP_NOP  = 3'b111;

    // Mirror bit i into bit DATA_W-1-i.
    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] res;
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = v[DATA_W-1-i];
        end
        return res;
    endfunction

endpackage

// File: rtl/brs_shifter.sv
// rtl/brs_shifter.sv - combinational next-value datapath for the result register
module brs_shifter
    import brs_pkg::*;
(
    input  logic [DATA_W-1:0] r,
    input  logic [DATA_W-1:0] d,
    input  logic [OP_W-1:0]   op,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] next_r
);

    logic [2*DATA_W-1:0] rol_wide;
    logic [2*DATA_W-1:0] ror_wide;
    logic signed [DATA_W-1:0] r_signed;

    // Rotations done on a doubled copy so the wrapped bits fall into the window.
    always_comb begin
        rol_wide = {r, r} << amt;
        ror_wide = {r, r} >> amt;
        r_signed = r;
    end

    // Select the operation result; NOP and unknown codes keep the register.
    always_comb begin
        next_r = r;
        case (op)
            OP_LOAD: next_r = d;
            OP_ROL:  next_r = rol_wide[2*DATA_W-1:DATA_W];
            OP_ROR:  next_r = ror_wide[DATA_W-1:0];
            OP_SHL:  next_r = r << amt;
            OP_SHR:  next_r = r >> amt;
            OP_SAR:  next_r = r_signed >>> amt;
            OP_BREV: next_r = bit_reverse(r);
            default: next_r = r;
        endcase
    end

endmodule

// File: rtl/tt_um_brs_3_core.sv
// rtl/tt_um_brs_3_core.sv - result register, command gating and pin wiring for the BRS core
module tt_um_brs_3_core
    import brs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] shift_r;
    logic [OP_W-1:0]   cmd_op;
    logic [AMT_W-1:0]  cmd_amt;
    logic              cmd_valid;
    logic              zero_flag;
    logic              unused_uio_in7;

    assign cmd_op         = uio_in[2:0];
    assign cmd_amt        = uio_in[5:3];
    assign cmd_valid      = uio_in[6];
    assign unused_uio_in7 = uio_in[7];

    brs_shifter u_shifter (
        .r      (r_q),
        .d      (ui_in),
        .op     (cmd_op),
        .amt    (cmd_amt),
        .next_r (shift_r)
    );

    // Accept a command only when both enable and the valid strobe are high.
    always_comb begin
        r_d = r_q;
        if (ena && cmd_valid) begin
            r_d = shift_r;
        end
    end

    // Result register; reset clears it without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign zero_flag = (r_q == '0);
    assign uo_out    = r_q;
    assign uio_out   = {zero_flag, 7'b0000000};
    assign uio_oe    = 8'h80;

endmodule

// File: tb/tb_tt_um_brs_3_core.sv
// tb/tb_tt_um_brs_3_core.sv - self-checking bench for tt_um_brs_3_core
module tb_tt_um_brs_3_core;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_fail;
    logic [7:0] model_r;

    tt_um_brs_3_core dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the operation rules written as integer arithmetic.
    function automatic logic [7:0] ref_next(input logic [7:0] r, input logic [7:0] d,
                                            input logic [2:0] op, input int amt);
        int v;
        int res;
        v = int'(r);
        res = v;
        case (op)
            3'd0: res = int'(d);
            3'd1: res = ((v << amt) | (v >> ((8 - amt) % 8))) & 255;
            3'd2: res = ((v >> amt) | (v << ((8 - amt) % 8))) & 255;
            3'd3: res = (v << amt) & 255;
            3'd4: res = v >> amt;
            3'd5: begin
                res = v >> amt;
                if (v >= 128) res = res | ((255 << (8 - amt)) & 255);
            end
            3'd6: begin
                res = 0;
                for (int i = 0; i < 8; i++) res = res | (((v >> i) & 1) << (7 - i));
            end
            default: res = v;
        endcase
        return 8'(res);
    endfunction

    // Drive one cycle of inputs, clock it, and advance the model.
    task automatic drive(input logic e, input logic v, input logic [2:0] op,
                         input logic [2:0] amt, input logic [7:0] d, input logic b7);
        ena    = e;
        ui_in  = d;
        uio_in = {b7, v, amt, op};
        @(posedge clk);
        #1;
        if (rst) model_r = 8'h00;
        else if (e && v) model_r = ref_next(model_r, d, op, int'(amt));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
        #3;
        model_r = 8'h00;
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out got %h want 00", uo_out); end
        n_checks++;
        if (uio_out !== 8'h80) begin n_fail++; $display("FAIL reset_uio_out got %h want 80", uio_out); end
        n_checks++;
        if (uio_oe !== 8'h80) begin n_fail++; $display("FAIL reset_uio_oe got %h want 80", uio_oe); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
            n_checks++;
            if (uo_out !== 8'h00) begin n_fail++; $display("FAIL idle_after_reset cyc %0d got %h want 00", i, uo_out); end
        end
    endtask

    task automatic test_rotate();
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'hB4, 1'b0);
        n_checks++;
        if (uo_out !== 8'hB4) begin n_fail++; $display("FAIL load_b4 got %h want b4", uo_out); end
        drive(1'b1, 1'b1, 3'd1, 3'd3, 8'h00, 1'b0);
        n_checks++;
        if (uo_out !== 8'hA5) begin n_fail++; $display("FAIL rol3 got %h want a5", uo_out); end
        drive(1'b1, 1'b1, 3'd2, 3'd3, 8'h00, 1'b0);
        n_checks++;
        if (uo_out !== 8'hB4) begin n_fail++; $display("FAIL ror3 got %h want b4", uo_out); end
        drive(1'b1, 1'b1, 3'd1, 3'd0, 8'hFF, 1'b1);
        n_checks++;
        if (uo_out !== 8'hB4) begin n_fail++; $display("FAIL rol0 got %h want b4", uo_out); end
    endtask

    task automatic test_shift();
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h81, 1'b0);
        drive(1'b1, 1'b1, 3'd3, 3'd1, 8'h00, 1'b0);
        n_checks++;
        if (uo_out !== 8'h02) begin n_fail++; $display("FAIL shl1 got %h want 02", uo_out); end
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h81, 1'b0);
        drive(1'b1, 1'b1, 3'd4, 3'd1, 8'h00, 1'b0);
        n_checks++;
        if (uo_out !== 8'h40) begin n_fail++; $display("FAIL shr1 got %h want 40", uo_out); end
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h81, 1'b0);
        drive(1'b1, 1'b1, 3'd5, 3'd2, 8'h00, 1'b0);
        n_checks++;
        if (uo_out !== 8'hE0) begin n_fail++; $display("FAIL sar2 got %h want e0", uo_out); end
    endtask

    task automatic test_brev_zero();
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h01, 1'b0);
        drive(1'b1, 1'b1, 3'd6, 3'd5, 8'h00, 1'b0);
        n_checks++;
        if (uo_out !== 8'h80) begin n_fail++; $display("FAIL brev got %h want 80", uo_out); end
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h80, 1'b0);
        drive(1'b1, 1'b1, 3'd4, 3'd7, 8'h00, 1'b0);
        n_checks++;
        if (uo_out !== 8'h01) begin n_fail++; $display("FAIL shr7 got %h want 01", uo_out); end
        n_checks++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL zflag_clear got %h want 00", uio_out); end
        drive(1'b1, 1'b1, 3'd4, 3'd1, 8'h00, 1'b0);
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL shr_to_zero got %h want 00", uo_out); end
        n_checks++;
        if (uio_out !== 8'h80) begin n_fail++; $display("FAIL zflag_set got %h want 80", uio_out); end
    endtask

    task automatic test_gating();
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h5A, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 3'd0, 8'h3C, 1'b0);
        n_checks++;
        if (uo_out !== 8'h5A) begin n_fail++; $display("FAIL ena_low got %h want 5a", uo_out); end
        drive(1'b1, 1'b0, 3'd0, 3'd0, 8'h3C, 1'b1);
        n_checks++;
        if (uo_out !== 8'h5A) begin n_fail++; $display("FAIL v_low got %h want 5a", uo_out); end
        drive(1'b1, 1'b1, 3'd7, 3'd7, 8'hFF, 1'b1);
        n_checks++;
        if (uo_out !== 8'h5A) begin n_fail++; $display("FAIL nop got %h want 5a", uo_out); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h55, 1'b0);
        n_checks++;
        if (uo_out !== 8'h55) begin n_fail++; $display("FAIL pre_reset_load got %h want 55", uo_out); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL async_clear got %h want 00", uo_out); end
        n_checks++;
        if (uio_out !== 8'h80) begin n_fail++; $display("FAIL async_zflag got %h want 80", uio_out); end
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'hAA, 1'b0);
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL cmd_during_rst got %h want 00", uo_out); end
        n_checks++;
        if (uio_oe !== 8'h80) begin n_fail++; $display("FAIL oe_during_rst got %h want 80", uio_oe); end
        rst = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'hAA, 1'b0);
        n_checks++;
        if (uo_out !== 8'hAA) begin n_fail++; $display("FAIL first_after_rst got %h want aa", uo_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want_z;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                  3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));
            want_z = (model_r == 8'h00) ? 8'h80 : 8'h00;
            n_checks++;
            if (uo_out !== model_r) begin
                n_fail++; $display("FAIL random_r cyc %0d got %h want %h", i, uo_out, model_r);
            end
            n_checks++;
            if (uio_out !== want_z) begin
                n_fail++; $display("FAIL random_z cyc %0d got %h want %h", i, uio_out, want_z);
            end
        end
        n_checks++;
        if (uio_oe !== 8'h80) begin n_fail++; $display("FAIL random_oe got %h want 80", uio_oe); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_r  = 8'h00;
        test_reset();
        test_rotate();
        test_shift();
        test_brev_zero();
        test_gating();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_brs_3_core.md
TT_UM_BRS_3_CORE -- requirements
Module: tt_um_BRS_3

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ena  input  1  enable; when 0, no state update, outputs still driven.
REQ-005 ui_in  input  8  data operand D[7:0].
REQ-006 uio_in  input  8  control: [2:0] opcode OP, [5:3] amount AMT (0..7), [6] valid strobe V, [7] ignored.
REQ-007 uo_out  output  8  result register R[7:0].
REQ-008 uio_out  output  8  bit 7 = zero flag Z (R==0); bits [6:0] SHALL be 0.
REQ-009 uio_oe  output  8  constant 8'h80 (bit 7 output, bits [6:0] inputs).

Function
REQ-010 R SHALL update on a rising clk edge only when ena=1 and V=1; otherwise R holds.
REQ-011 Latency SHALL be one cycle: the result of an accepted command appears on uo_out after the edge that samples it.
REQ-012 OP=000 LOAD: R <= D.
REQ-013 OP=001 ROL: R <= R rotated left by AMT.
REQ-014 OP=010 ROR: R <= R rotated right by AMT.
REQ-015 OP=011 SHL: R <= R shifted left by AMT, zero fill.
REQ-016 OP=100 SHR: R <= R shifted right by AMT, zero fill.
REQ-017 OP=101 SAR: R <= R shifted right by AMT, fill with R[7].
REQ-018 OP=110 BREV: R <= bit-reverse of R (R[0]->bit7 ... R[7]->bit0); AMT ignored.
REQ-019 OP=111 NOP: R holds.
REQ-020 AMT=0 SHALL leave R unchanged for ROL/ROR/SHL/SHR/SAR; rotation is modulo 8, no wrap beyond 7 possible.
REQ-021 Z SHALL be combinational from the registered R (Z=1 iff R==8'h00), valid in the same cycle R changes.
REQ-022 Commands on consecutive cycles SHALL chain, each operating on the R produced by the previous edge.
REQ-023 uio_in[7] and all inputs outside an accepted command SHALL have no effect.

Reset
REQ-024 Asserting rst SHALL immediately (without clk) force R=8'h00, hence uo_out=8'h00 and Z=1.
REQ-025 rst asserted mid-stream SHALL discard any command sampled in the same cycle; first command accepted on the first rising edge after rst deasserts.
REQ-026 uio_oe and uio_out[6:0] SHALL hold their constant values during and after reset.

Structure
REQ-027 Opcode constants (LOAD, ROL, ROR, SHL, SHR, SAR, BREV, NOP) SHALL live in shared package brs_pkg.
REQ-028 The shift/rotate/reverse datapath SHALL be a purely combinational sub-module brs_shifter (inputs R, D, OP, AMT; output next-R); the top holds only the register, enable gating and output wiring.

Verification
REQ-029 Reset: rst=1 -> uo_out=00, uio_out=80, uio_oe=80; rst=0 with V=0 for 5 cycles -> uo_out stays 00.
REQ-030 LOAD D=0xB4 then ROL AMT=3 -> uo_out 0xB4 then 0xA5; ROR AMT=3 -> 0xB4.
REQ-031 LOAD 0x81; SHL AMT=1 -> 0x02; LOAD 0x81; SHR AMT=1 -> 0x40; LOAD 0x81; SAR AMT=2 -> 0xE0.
REQ-032 LOAD 0x01; BREV -> 0x80; LOAD 0x80; SHR AMT=7 -> 0x01; SHR AMT=1 -> 0x00 with uio_out[7]=1.
REQ-033 Gating: LOAD 0x3C with ena=0 or V=0 -> R unchanged; NOP with D=0xFF -> R unchanged.
REQ-034 Async reset: LOAD 0x55, assert rst between clk edges -> uo_out=00 before next edge; command present during rst ignored.
